// File: rtl/uart_pkg.sv
// Shared UART constants: default clock/baud, frame bit indices, data width,
// receiver FSM state codes and the clocks-per-bit helper.
package uart_pkg;

  localparam int FCLK_DEF    = 50000000;
  localparam int COM_VEL_DEF = 115200;
  localparam int DATA_W      = 8;

  // Bit index within a frame: 0 = start, 1..8 = data, 9 = stop.
  localparam logic [3:0] BIT_START = 4'd0;
  localparam logic [3:0] BIT_STOP  = 4'd9;

  // Receiver FSM; the state bit is also the en_rx output.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  // Clocks per bit, truncating division.
  function automatic int clocks_per_bit(input int fclk, input int vel);
    return fclk / vel;
  endfunction

endpackage

// File: rtl/urxd_1byte_if.sv
// Receive-side bundle of the 1-byte UART receiver: serial input plus the
// decoded byte, status strobes and frame-progress debug signals.
//
// Handshake: ok_rx and err_fr are valid-only strobes with no ready. Each is
// high for exactly one clock and they are never high together. dat is
// updated in the same cycle that ok_rx rises and holds until the next good
// frame, so a consumer may read it in the pulse cycle or any time later.
interface urxd_1byte_if;
  import uart_pkg::*;

  logic              rxd;
  logic [DATA_W-1:0] dat;
  logic              ok_rx;
  logic              err_fr;
  logic              en_rx;
  logic [3:0]        cb_bit;
  logic              ce;

  // Receiver side: reads the line, drives results.
  modport master (
    input  rxd,
    output dat, ok_rx, err_fr, en_rx, cb_bit, ce
  );

  // Line driver / result consumer side.
  modport slave (
    output rxd,
    input  dat, ok_rx, err_fr, en_rx, cb_bit, ce
  );

endinterface

// File: rtl/rxd_sync.sv
// Two-flop synchronizer for the asynchronous rxd pin plus one history flop,
// used to detect a high-to-low transition on the synchronized line.
module rxd_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rxd_s,
  output logic fall_raw
);

  logic rxd_m;
  logic rxd_d;

  // Metastability chain and edge history; all reset to the idle level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_d <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_d <= rxd_s;
    end
  end

  assign fall_raw = rxd_d & ~rxd_s;

endmodule

// File: rtl/urxd_1byte.sv
// 8N1 UART receiver for one byte. A falling edge on the synchronized line
// starts a frame; each bit is sampled once at mid-bit, data is LSB first,
// and the frame ends with a one-cycle ok_rx or err_fr strobe.
module urxd_1byte
  import uart_pkg::*;
#(
  parameter int Fclk    = FCLK_DEF,
  parameter int COM_vel = COM_VEL_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  urxd_1byte_if.master rx
);

  localparam int N    = clocks_per_bit(Fclk, COM_vel);
  localparam int HALF = N / 2;

  localparam logic [8:0] TACT_LAST = 9'(N - 1);
  localparam logic [8:0] TACT_MID  = 9'(HALF - 1);

  logic [0:0]        state;
  logic              en_rx;
  logic [8:0]        cb_tact;
  logic [3:0]        cb_bit;
  logic [DATA_W-1:0] sr_dat;
  logic [DATA_W-1:0] dat;
  logic              ok_rx;
  logic              err_fr;

  logic rxd_s;
  logic fall_raw;
  logic fall;
  logic smp;
  logic ce;
  logic smp_start;
  logic smp_data;
  logic smp_stop;
  logic false_start;

  rxd_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rxd      (rx.rxd),
    .rxd_s    (rxd_s),
    .fall_raw (fall_raw)
  );

  assign en_rx = (state == ST_FRAME);

  // Falling edges are only a start while idle; inside a frame they are data.
  assign fall        = fall_raw & ~en_rx;
  assign smp         = en_rx & (cb_tact == TACT_MID);
  assign ce          = en_rx & (cb_tact == TACT_LAST);
  assign smp_start   = smp & (cb_bit == BIT_START);
  assign smp_data    = smp & (cb_bit > BIT_START) & (cb_bit < BIT_STOP);
  assign smp_stop    = smp & (cb_bit == BIT_STOP);
  assign false_start = smp_start & rxd_s;

  // Frame FSM. Leaving at mid-stop re-arms early enough to catch a following
  // start edge even when the stop bit is exactly one bit period long.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (fall) state <= ST_FRAME;
        ST_FRAME: if (false_start || smp_stop) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Clock-in-bit and bit-index counters, both restarted by the start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cb_tact <= '0;
      cb_bit  <= '0;
    end else if (fall) begin
      cb_tact <= '0;
      cb_bit  <= BIT_START;
    end else if (en_rx) begin
      cb_tact <= ce ? 9'd0 : cb_tact + 9'd1;
      if (ce) cb_bit <= cb_bit + 4'd1;
    end
  end

  // Data shift register, LSB arrives first so it shifts in from the top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_dat <= '0;
    end else if (smp_data) begin
      sr_dat <= {rxd_s, sr_dat[DATA_W-1:1]};
    end
  end

  // Result registers: stop bit high publishes the byte, low flags a framing
  // error and leaves the previous byte in place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat    <= '0;
      ok_rx  <= 1'b0;
      err_fr <= 1'b0;
    end else begin
      ok_rx  <= 1'b0;
      err_fr <= 1'b0;
      if (smp_stop) begin
        if (rxd_s) begin
          dat   <= sr_dat;
          ok_rx <= 1'b1;
        end else begin
          err_fr <= 1'b1;
        end
      end
    end
  end

  assign rx.dat    = dat;
  assign rx.ok_rx  = ok_rx;
  assign rx.err_fr = err_fr;
  assign rx.en_rx  = en_rx;
  assign rx.cb_bit = cb_bit;
  assign rx.ce     = ce;

endmodule

// File: tb/tb_urxd_1byte.sv
// Testbench for urxd_1byte at the default 50 MHz / 115200 baud setting.
// Frames are described as (byte, stop level, bit period); the reference
// model turns each into the expected strobe kind, byte and strobe cycle.
module tb_urxd_1byte;
  import uart_pkg::*;

  localparam int N    = FCLK_DEF / COM_VEL_DEF;   // 434
  localparam int HALF = N / 2;                    // 217
  localparam int EW   = 41;                       // {is_ok, byte, cycle}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  urxd_1byte_if rx_if ();

  urxd_1byte dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_if)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  logic [7:0]    model_dat = 8'h00;
  int            checks = 0;
  int            errors = 0;
  int            both_cnt = 0;
  int            en_cnt = 0;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rx_if.ok_rx)  obs_q.push_back({1'b1, rx_if.dat, 32'(cyc)});
    if (rx_if.err_fr) obs_q.push_back({1'b0, 8'h00, 32'(cyc)});
    if (rx_if.ok_rx && rx_if.err_fr) both_cnt++;
    if (rx_if.en_rx) en_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare everything seen since the last call against the model.
  task automatic score(input string tag);
    check({tag, "_events"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check({tag, "_event"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
    check({tag, "_dat"}, 64'(rx_if.dat), 64'(model_dat));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_dat"},    64'(rx_if.dat),    64'h0);
    check({tag, "_ok_rx"},  64'(rx_if.ok_rx),  64'h0);
    check({tag, "_err_fr"}, 64'(rx_if.err_fr), 64'h0);
    check({tag, "_en_rx"},  64'(rx_if.en_rx),  64'h0);
    check({tag, "_cb_bit"}, 64'(rx_if.cb_bit), 64'h0);
    check({tag, "_ce"},     64'(rx_if.ce),     64'h0);
  endtask

  // ---------------- driver ----------------
  task automatic idle(input int n);
    rx_if.rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drive one 8N1 frame starting at the current falling edge. The start edge
  // reaches the receiver's fall condition three rising edges later (two
  // synchronizer flops plus the history flop); that edge is t0, the stop
  // sample is at t0 + HALF + 9N and the strobe is visible right after it.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per);
    logic [9:0] fr;
    int c_start;
    fr = {stop, b, 1'b0};
    c_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx_if.rxd = fr[i];
      repeat (per) @(negedge clk);
    end
    if (stop) begin
      exp_q.push_back({1'b1, b, 32'(c_start + 3 + HALF + 9 * N)});
      model_dat = b;
    end else begin
      exp_q.push_back({1'b0, 8'h00, 32'(c_start + 3 + HALF + 9 * N)});
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c;
    int en_base;
    logic [7:0] rb;
    logic rstop;
    int rper;

    rst_n = 1'b0;
    rx_if.rxd = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(20);

    // Nominal frame.
    send_frame(8'hA5, 1'b1, N);
    idle(N);
    score("nominal");

    // Short low glitch: false start, en_rx drops right after the start sample.
    rx_if.rxd = 1'b0;
    c = cyc;
    repeat (100) @(negedge clk);
    rx_if.rxd = 1'b1;
    while (cyc < c + 2 + HALF) @(negedge clk);
    check("glitch_en_before", 64'(rx_if.en_rx), 64'h1);
    check("glitch_cb_bit", 64'(rx_if.cb_bit), 64'h0);
    @(negedge clk);
    check("glitch_en_after", 64'(rx_if.en_rx), 64'h0);
    idle(N);
    score("glitch");

    // Framing error followed by a long break.
    send_frame(8'h3C, 1'b0, N);
    en_base = en_cnt;
    repeat (20 * N) @(negedge clk);
    check("break_en_cycles", 64'(en_cnt - en_base), 64'h0);
    idle(N);
    score("framing");

    // Back-to-back frames with exactly N-cycle stop bits.
    send_frame(8'h00, 1'b1, N);
    send_frame(8'hFF, 1'b1, N);
    idle(N);
    score("b2b");

    // Reset during data bit 4 of an all-ones frame, then a clean frame.
    rx_if.rxd = 1'b0;
    repeat (N) @(negedge clk);
    rx_if.rxd = 1'b1;
    repeat (4 * N + HALF) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_dat = 8'h00;
    check_reset_values("midreset");
    idle(2 * N);
    score("midreset_idle");
    send_frame(8'h5A, 1'b1, N);
    idle(N);
    score("after_reset");

    // Transmitter bit period off by about +-4%.
    send_frame(8'h55, 1'b1, 417);
    idle(N);
    score("tol_fast");
    send_frame(8'h55, 1'b1, 451);
    idle(N);
    score("tol_slow");

    // Random bytes, random stop level, random period within tolerance.
    for (int i = 0; i < 4; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rper  = $urandom_range(N - 15, N + 15);
      send_frame(rb, rstop, rper);
      idle(N);
      score("random");
    end

    check("never_both", 64'(both_cnt), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
